// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM sequencing controller.
// SRAM_CTRL_WRITE_VERIFY_EN adds the read-back verify states and changes the write latency.
package sram_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_PRECH         = 3'd1,
    ST_DRIVE         = 3'd2,
    ST_ACCESS        = 3'd3,
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    ST_RECOVER       = 3'd4,
    ST_VERIFY_PRECH  = 3'd5,
    ST_VERIFY_ACCESS = 3'd6
`else
    ST_RECOVER       = 3'd4
`endif
  } state_t;

  // Cycles from handshake edge to the rsp_valid cycle, inclusive.
  function automatic int read_latency(input int prech_cyc, input int wl_cyc);
    return prech_cyc + wl_cyc + 1;
  endfunction

  function automatic int write_latency(input int prech_cyc, input int wl_cyc);
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    return 1 + wl_cyc + prech_cyc + wl_cyc + 1;
`else
    return 1 + wl_cyc + 1;
`endif
  endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// Row address to one-hot wordline decoder; all wordlines stay low unless enabled.
module sram_wl_decoder #(
  parameter int ADDR_W = 4
) (
  input  logic                   en_i,
  input  logic [ADDR_W-1:0]      addr_i,
  output logic [(1<<ADDR_W)-1:0] wl_o
);

  always_comb begin
    wl_o = '0;
    if (en_i) wl_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/sram_ctrl.sv
// Single-word SRAM sequencer: precharge / drive / wordline access / sense, one response per request.
// Define SRAM_CTRL_WRITE_VERIFY_EN to read back every write and flag mismatches on rsp_err.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int PRECH_CYC = 2,
  parameter int WL_CYC    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
  // the requester keeps req_valid and its fields stable until then. rsp_valid is a 1-cycle pulse.
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [(1<<ADDR_W)-1:0] wl,
  output logic                   prech,
  output logic                   wdrv_en,
  output logic [DATA_W-1:0]      wdrv_data,
  output logic                   sense_en,
  input  logic [DATA_W-1:0]      sense_data,
  output state_t                 dbg_state
);

  localparam logic [CNT_W-1:0] PRECH_LEN = CNT_W'(PRECH_CYC);
  localparam logic [CNT_W-1:0] WL_LEN    = CNT_W'(WL_CYC);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_c;
  logic                wl_en;
  logic                last;

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  logic                err_q, err_d;
`endif

  assign last = (cnt_q == ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    err_d     = err_q;
`endif
    ready_c   = 1'b0;
    prech     = 1'b0;
    wdrv_en   = 1'b0;
    sense_en  = 1'b0;
    wl_en     = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
          err_d   = 1'b0;
`endif
          // Writes skip precharge: the drivers own the bitlines for a settle cycle first.
          if (req_we) begin
            state_d = ST_DRIVE;
            cnt_d   = ONE;
          end else begin
            state_d = ST_PRECH;
            cnt_d   = PRECH_LEN;
          end
        end
      end

      ST_PRECH: begin
        prech = 1'b1;
        if (last) begin
          state_d = ST_ACCESS;
          cnt_d   = WL_LEN;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      ST_DRIVE: begin
        wdrv_en = 1'b1;
        state_d = ST_ACCESS;
        cnt_d   = WL_LEN;
      end

      ST_ACCESS: begin
        wl_en    = 1'b1;
        wdrv_en  = we_q;
        sense_en = !we_q && last;
        if (last) begin
          if (!we_q) rdata_d = sense_data;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
          if (we_q) begin
            state_d = ST_VERIFY_PRECH;
            cnt_d   = PRECH_LEN;
          end else begin
            state_d = ST_RECOVER;
            cnt_d   = ONE;
          end
`else
          state_d = ST_RECOVER;
          cnt_d   = ONE;
`endif
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
      ST_VERIFY_PRECH: begin
        prech = 1'b1;
        if (last) begin
          state_d = ST_VERIFY_ACCESS;
          cnt_d   = WL_LEN;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end

      ST_VERIFY_ACCESS: begin
        wl_en    = 1'b1;
        sense_en = last;
        if (last) begin
          err_d   = (sense_data != wdata_q);
          state_d = ST_RECOVER;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
`endif

      ST_RECOVER: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
        cnt_d     = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  sram_wl_decoder #(.ADDR_W(ADDR_W)) u_wl_dec (
    .en_i   (wl_en),
    .addr_i (addr_q),
    .wl_o   (wl)
  );

  // Ready is masked by rst directly so it reads 0 for the whole reset pulse.
  assign req_ready = ready_c && !rst;
  assign wdrv_data = wdrv_en ? wdata_q : '0;
  assign rsp_rdata = rdata_q;
  assign dbg_state = state_q;

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
  assign rsp_err = rsp_valid && err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
